xcore_gnrl_fifo_ctrl: RTL and testbench
=======================================

// Module: xcore_gnrl_fifo_ctrl
// PURPOSE
//   Synchronous FIFO controller that drives the general dual-port no-reset RAM.
//   It converts a valid/ready push stream into RAM write cycles, and the RAM read
//   data into a first-word-fall-through valid/ready pop stream.
//   Used for CPU queues such as the IFU fetch buffer and the LSU store buffer.
// PARAMETERS
//   DP      8   FIFO depth in entries, >=2; need not be a power of 2
//   DW      32  data width
//   AW      3   RAM address width; must satisfy 2**AW >= DP
//   AF_LVL  6   almost_full asserts when count >= AF_LVL (1..DP)
// PORTS
//   clk          in   1     clock, rising edge
//   rst_n        in   1     reset, asynchronous, active-low
//   flush        in   1     synchronous clear of all entries
//   i_valid      in   1     push request
//   i_ready      out  1     push accepted when i_valid & i_ready
//   i_data       in   DW    push data
//   o_valid      out  1     head entry present
//   o_ready      in   1     pop when o_valid & o_ready
//   o_data       out  DW    head entry data (= ram_dout)
//   count        out  AW+1  number of stored entries, 0..DP
//   almost_full  out  1     count >= AF_LVL
//   ram_cs       out  1     RAM chip select
//   ram_we       out  1     RAM write enable
//   ram_waddr    out  AW    RAM write address (= wr_ptr)
//   ram_raddr    out  AW    RAM read address (= rd_ptr)
//   ram_din      out  DW    RAM write data (= i_data)
//   ram_dout     in   DW    RAM read data, combinational from ram_raddr
// BEHAVIOUR
//   State: wr_ptr, rd_ptr (AW bits, 0..DP-1), cnt (AW+1 bits). All are async-cleared
//     to 0 by rst_n=0. During reset: i_ready=0, o_valid=0, count=0, almost_full=0,
//     ram_we=0.
//   ram_cs = 1 whenever rst_n=1, so the RAM read address follows rd_ptr every cycle.
//   empty = (cnt==0) and full = (cnt==DP), both decoded from cnt.
//   i_ready = ~full & ~flush.
//   o_valid = ~empty & ~flush.
//   push = i_valid & i_ready.
//   pop = o_valid & o_ready.
//   ram_we = push, combinational. The RAM captures i_data at the same rising edge.
//   Pointer update at the edge:
//     - on push, wr_ptr increments and wraps from DP-1 to 0;
//     - on pop, rd_ptr increments with the same wrap.
//   cnt update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
//   Latency: a word pushed at edge N is on o_data with o_valid=1 in the cycle after N.
//     There is no same-cycle bypass: the empty-to-output latency is 1 cycle.
//   o_data = ram_dout = entry at rd_ptr. It must remain stable while o_valid=1 and
//     o_ready=0.
//   Full with i_valid: no push. A pop in that cycle frees a slot, and i_ready rises
//     in the next cycle, not in the same cycle.
//   Empty with o_ready: no pop. rd_ptr and cnt are unchanged.
//   Simultaneous push and pop with 0 < cnt < DP: both pointers advance and cnt holds.
//   flush=1 at an edge: wr_ptr, rd_ptr and cnt go to 0. In that cycle i_ready=0 and
//     o_valid=0, so no handshake completes. RAM contents are left stale, which is
//     harmless because stale entries are never exposed.
//   Reset mid-operation: all state clears immediately and asynchronously. Stored
//     entries are discarded.
//   count = cnt, registered. almost_full = (cnt >= AF_LVL), decoded from cnt.
// TESTING
//   T1: reset, then push 0xA1,0xA2,0xA3 on back-to-back cycles with o_ready=0
//       -> count=3; o_valid=1 one cycle after the first push; o_data=0xA1.
//   T2: DP=8, push 8 words, i_valid held high -> i_ready=0 at count=8;
//       almost_full=1 from count=6; the 9th word is not written (ram_we=0).
//   T3: full FIFO, assert o_ready for 1 cycle with i_valid=1
//       -> 1 pop, no push that cycle; i_ready=1 next cycle; the push then occurs
//       and count returns to 8.
//   T4: DP=6, 20 words streamed with i_valid=o_ready=1 continuously
//       -> pointers wrap 5->0; output order matches input; count stays steady
//       in steady state.
//   T5: count=4, pulse flush with i_valid=o_valid=1
//       -> next cycle count=0, o_valid=0; no handshake in the flush cycle.
//   T6: drop rst_n asynchronously mid-stream at count=5 -> count=0, o_valid=0,
//       i_ready=0 without waiting for a clock edge; normal operation resumes
//       after release.

Source files
------------

// File: rtl/xcore_gnrl_fifo_ctrl.sv
// Synchronous FIFO controller for an external no-reset dual-port RAM.
// Converts a valid/ready push stream into RAM writes and exposes the head entry first-word-fall-through.
module xcore_gnrl_fifo_ctrl #(
  parameter int DP     = 8,
  parameter int DW     = 32,
  parameter int AW     = 3,
  parameter int AF_LVL = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DP - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DP);
  localparam logic [AW:0]   AF_CNT   = (AW + 1)'(AF_LVL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, push, pop;

  // Depth need not be a power of two, so wrap explicitly at DP-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    // rst_n gates the push side so nothing is accepted or written while in reset.
    i_ready = rst_n & ~full & ~flush;
    o_valid = rst_n & ~empty & ~flush;
    push    = i_valid & i_ready;
    pop     = o_valid & o_ready;
  end

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the RAM array itself is never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    ram_cs      = rst_n;
    ram_we      = push;
    ram_waddr   = wr_ptr_q;
    ram_raddr   = rd_ptr_q;
    ram_din     = i_data;
    o_data      = ram_dout;
    count       = cnt_q;
    almost_full = (cnt_q >= AF_CNT);
  end

endmodule

// File: tb/tb_xcore_gnrl_fifo_ctrl.sv
// Self-checking bench: DP=8 instance driven from a vector table plus hand sequences,
// DP=6 instance used for a continuous streaming/wrap test.
module tb_xcore_gnrl_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: DP=8, AF_LVL=6 ----------------
  logic        a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
  logic [31:0] a_idata = '0;
  logic        a_ir, a_ov, a_af, a_cs, a_we;
  logic [31:0] a_odata, a_din, a_dout;
  logic [3:0]  a_cnt;
  logic [2:0]  a_waddr, a_raddr;
  logic [31:0] a_mem [8];

  xcore_gnrl_fifo_ctrl #(.DP(8), .DW(32), .AW(3), .AF_LVL(6)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .i_valid(a_iv), .i_ready(a_ir), .i_data(a_idata),
    .o_valid(a_ov), .o_ready(a_or), .o_data(a_odata),
    .count(a_cnt), .almost_full(a_af),
    .ram_cs(a_cs), .ram_we(a_we), .ram_waddr(a_waddr), .ram_raddr(a_raddr),
    .ram_din(a_din), .ram_dout(a_dout)
  );

  always @(posedge clk) if (a_cs && a_we) a_mem[a_waddr] <= a_din;
  assign a_dout = a_mem[a_raddr];

  // ---------------- instance B: DP=6, AF_LVL=4 ----------------
  logic        b_iv = 1'b0, b_or = 1'b0;
  logic [31:0] b_idata = '0;
  logic        b_ir, b_ov, b_af, b_cs, b_we;
  logic [31:0] b_odata, b_din, b_dout;
  logic [3:0]  b_cnt;
  logic [2:0]  b_waddr, b_raddr;
  logic [31:0] b_mem [8];

  xcore_gnrl_fifo_ctrl #(.DP(6), .DW(32), .AW(3), .AF_LVL(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .i_valid(b_iv), .i_ready(b_ir), .i_data(b_idata),
    .o_valid(b_ov), .o_ready(b_or), .o_data(b_odata),
    .count(b_cnt), .almost_full(b_af),
    .ram_cs(b_cs), .ram_we(b_we), .ram_waddr(b_waddr), .ram_raddr(b_raddr),
    .ram_din(b_din), .ram_dout(b_dout)
  );

  always @(posedge clk) if (b_cs && b_we) b_mem[b_waddr] <= b_din;
  assign b_dout = b_mem[b_raddr];

  // ---------------- vector table ----------------
  typedef struct {
    logic        fl, iv, orr;
    logic [31:0] din;
    logic        ir, ov;
    logic [31:0] od;
    logic [3:0]  cnt;
    logic        af, we;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic fl, iv, orr, input logic [31:0] din,
                              input logic ir, ov, input logic [31:0] od,
                              input logic [3:0] cnt, input logic af, we);
    vec_t v;
    v.fl = fl; v.iv = iv; v.orr = orr; v.din = din;
    v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt; v.af = af; v.we = we;
    return v;
  endfunction

  // Inputs applied in a cycle; expected outputs are those seen in that same cycle, before the edge.
  initial begin
    //              fl iv or din        ir ov od         cnt af we
    vecs[0]  = mk(0, 1, 0, 32'hA1,   1, 0, 32'h0,   0, 0, 1);
    vecs[1]  = mk(0, 1, 0, 32'hA2,   1, 1, 32'hA1,  1, 0, 1);
    vecs[2]  = mk(0, 1, 0, 32'hA3,   1, 1, 32'hA1,  2, 0, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,    1, 1, 32'hA1,  3, 0, 0);
    vecs[4]  = mk(0, 1, 0, 32'hA4,   1, 1, 32'hA1,  3, 0, 1);
    vecs[5]  = mk(0, 1, 0, 32'hA5,   1, 1, 32'hA1,  4, 0, 1);
    vecs[6]  = mk(0, 1, 0, 32'hA6,   1, 1, 32'hA1,  5, 0, 1);
    vecs[7]  = mk(0, 1, 0, 32'hA7,   1, 1, 32'hA1,  6, 1, 1);
    vecs[8]  = mk(0, 1, 0, 32'hA8,   1, 1, 32'hA1,  7, 1, 1);
    vecs[9]  = mk(0, 1, 0, 32'h99,   0, 1, 32'hA1,  8, 1, 0);
    vecs[10] = mk(0, 1, 1, 32'h99,   0, 1, 32'hA1,  8, 1, 0);
    vecs[11] = mk(0, 1, 0, 32'hB0,   1, 1, 32'hA2,  7, 1, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,    0, 1, 32'hA2,  8, 1, 0);
    vecs[13] = mk(0, 0, 1, 32'h0,    0, 1, 32'hA2,  8, 1, 0);
    vecs[14] = mk(0, 0, 1, 32'h0,    1, 1, 32'hA3,  7, 1, 0);
    vecs[15] = mk(0, 0, 1, 32'h0,    1, 1, 32'hA4,  6, 1, 0);
    vecs[16] = mk(0, 0, 1, 32'h0,    1, 1, 32'hA5,  5, 0, 0);
    vecs[17] = mk(1, 1, 1, 32'hCC,   0, 0, 32'h0,   4, 0, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0, 0);
    vecs[19] = mk(0, 1, 0, 32'hD1,   1, 0, 32'h0,   0, 0, 1);
    vecs[20] = mk(0, 1, 1, 32'hD2,   1, 1, 32'hD1,  1, 0, 1);
    vecs[21] = mk(0, 0, 0, 32'h0,    1, 1, 32'hD2,  1, 0, 0);
    vecs[22] = mk(0, 0, 1, 32'h0,    1, 1, 32'hD2,  1, 0, 0);
    vecs[23] = mk(0, 0, 1, 32'h0,    1, 0, 32'h0,   0, 0, 0);
    vecs[24] = mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0, 0);
  end

  initial begin
    // Reset state, with push/pop requests asserted to prove they are blocked.
    a_iv = 1'b1; a_or = 1'b1; a_idata = 32'h55;
    #2;
    check("rst_i_ready", a_ir, 0);
    check("rst_o_valid", a_ov, 0);
    check("rst_count", a_cnt, 0);
    check("rst_almost_full", a_af, 0);
    check("rst_ram_we", a_we, 0);
    check("rst_ram_cs", a_cs, 0);
    a_iv = 1'b0; a_or = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven: T1, T2, T3, T5, concurrent push/pop, empty pop.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_flush = vecs[i].fl; a_iv = vecs[i].iv; a_or = vecs[i].orr; a_idata = vecs[i].din;
      #1;
      check($sformatf("v%0d_i_ready", i), a_ir, vecs[i].ir);
      check($sformatf("v%0d_o_valid", i), a_ov, vecs[i].ov);
      if (vecs[i].ov) check($sformatf("v%0d_o_data", i), a_odata, vecs[i].od);
      check($sformatf("v%0d_count", i), a_cnt, vecs[i].cnt);
      check($sformatf("v%0d_almost_full", i), a_af, vecs[i].af);
      check($sformatf("v%0d_ram_we", i), a_we, vecs[i].we);
      if (vecs[i].we) check($sformatf("v%0d_ram_din", i), a_din, vecs[i].din);
    end
    @(negedge clk);
    a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0;

    // T4: DP=6 continuous stream of 20 words; pointers wrap 5->0, order preserved, count steady at 1.
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      b_iv = (k < 20); b_or = 1'b1; b_idata = 32'h100 + k;
      #1;
      if (k < 20) check($sformatf("s%0d_waddr", k), b_waddr, k % 6);
      if (k == 0) begin
        check("s0_o_valid", b_ov, 0);
        check("s0_count", b_cnt, 0);
      end else begin
        check($sformatf("s%0d_o_valid", k), b_ov, 1);
        check($sformatf("s%0d_o_data", k), b_odata, 32'h100 + k - 1);
        check($sformatf("s%0d_raddr", k), b_raddr, (k - 1) % 6);
        check($sformatf("s%0d_count", k), b_cnt, 1);
      end
    end
    @(negedge clk);
    b_iv = 1'b0; b_or = 1'b0;
    #1;
    check("s_end_count", b_cnt, 0);
    check("s_end_o_valid", b_ov, 0);

    // T6: asynchronous reset mid-stream at count=5 on instance A (empty after the table).
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_iv = 1'b1; a_idata = 32'hE0 + k;
    end
    @(negedge clk);
    a_iv = 1'b1; a_idata = 32'hEE; a_or = 1'b0;
    #1;
    check("t6_pre_count", a_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", a_cnt, 0);
    check("t6_rst_o_valid", a_ov, 0);
    check("t6_rst_i_ready", a_ir, 0);
    check("t6_rst_ram_we", a_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_iv = 1'b1; a_idata = 32'hF1;
    #1;
    check("t6_resume_i_ready", a_ir, 1);
    check("t6_resume_waddr", a_waddr, 0);
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    check("t6_resume_count", a_cnt, 1);
    check("t6_resume_o_valid", a_ov, 1);
    check("t6_resume_o_data", a_odata, 32'hF1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
